// File: rtl/cv32e40x_xif_aes_queue.sv
// Multi-entry AES32 (aes32{e,d}s{,m}i) XIF coprocessor: in-order issue queue with per-entry
// commit/kill tracking, a head FSM driving an AES32 round datapath, and a backpressured result port.
module cv32e40x_xif_aes_queue #(
    parameter int unsigned X_ID_WIDTH  = 4,
    parameter int unsigned X_RFR_WIDTH = 32,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned FU_LATENCY  = 1,
    parameter bit          SAES_DEC_EN = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   issue_valid_i,
    output logic                   issue_ready_o,
    input  logic [31:0]            issue_instr_i,
    input  logic [X_ID_WIDTH-1:0]  issue_id_i,
    input  logic [X_RFR_WIDTH-1:0] issue_rs0_i,
    input  logic [X_RFR_WIDTH-1:0] issue_rs1_i,
    input  logic [1:0]             issue_rs_valid_i,
    output logic                   issue_accept_o,
    output logic                   issue_writeback_o,
    input  logic                   commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]  commit_id_i,
    input  logic                   commit_kill_i,
    output logic                   result_valid_o,
    input  logic                   result_ready_i,
    output logic [X_ID_WIDTH-1:0]  result_id_o,
    output logic [X_RFR_WIDTH-1:0] result_data_o,
    output logic [4:0]             result_rd_o,
    output logic                   result_we_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LAT_W = (FU_LATENCY > 1) ? $clog2(FU_LATENCY) : 1;
    localparam logic [6:0] OPC_AES  = 7'b0110011;
    localparam logic [4:0] F5_ESI   = 5'b10001;
    localparam logic [4:0] F5_ESMI  = 5'b10011;
    localparam logic [4:0] F5_DSI   = 5'b10101;
    localparam logic [4:0] F5_DSMI  = 5'b10111;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_RESP} state_e;

    function automatic logic [7:0] f_xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = f_xt(p);
        end
        return r;
    endfunction

    // GF(2^8) inverse as a^254 = prod a^(2^k), k=1..7; maps 0 to 0
    function automatic logic [7:0] f_ginv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = f_gmul(p, p);
            r = f_gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] f_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = f_ginv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] f_isbox(input logic [7:0] x);
        return f_ginv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
    endfunction

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;
    logic [DEPTH-1:0]        r_vld;
    logic [DEPTH-1:0]        r_cmt;
    logic [DEPTH-1:0]        r_kill;
    logic [X_ID_WIDTH-1:0]   r_id  [DEPTH];
    logic [X_RFR_WIDTH-1:0]  r_rs1 [DEPTH];
    logic [X_RFR_WIDTH-1:0]  r_rs2 [DEPTH];
    logic [1:0]              r_bs  [DEPTH];
    logic                    r_dec [DEPTH];
    logic                    r_mix [DEPTH];
    logic [4:0]              r_rd  [DEPTH];
    logic [X_ID_WIDTH-1:0]   r_x_id;
    logic [X_RFR_WIDTH-1:0]  r_x_rs1;
    logic [X_RFR_WIDTH-1:0]  r_x_rs2;
    logic [1:0]              r_x_bs;
    logic                    r_x_dec;
    logic                    r_x_mix;
    logic [4:0]              r_x_rd;
    logic [LAT_W-1:0]        r_cnt;
    logic                    r_res_valid;
    logic [X_ID_WIDTH-1:0]   r_res_id;
    logic [X_RFR_WIDTH-1:0]  r_res_data;
    logic [4:0]              r_res_rd;

    logic                    w_full;
    logic [4:0]              w_f5;
    logic                    w_is_aes;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_latch;
    logic                    w_res_load;
    logic                    w_res_done;
    logic                    w_new_match;
    logic [7:0]              w_byte;
    logic [7:0]              w_sb;
    logic [31:0]             w_mix;
    logic [31:0]             w_rot;
    logic [X_RFR_WIDTH-1:0]  w_result;
    logic                    w_unused;

    assign w_unused = ^issue_instr_i[24:12];

    // Request decode
    assign w_f5     = issue_instr_i[29:25];
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_is_aes = (issue_instr_i[6:0] == OPC_AES)
                   && ((w_f5 == F5_ESI) || (w_f5 == F5_ESMI)
                    || (SAES_DEC_EN && ((w_f5 == F5_DSI) || (w_f5 == F5_DSMI))));
    assign issue_ready_o     = !w_full;
    assign issue_accept_o    = issue_valid_i && !w_full && w_is_aes && (issue_rs_valid_i == 2'b11);
    assign issue_writeback_o = issue_accept_o;
    assign w_push            = issue_accept_o;
    assign w_new_match       = commit_valid_i && (commit_id_i == issue_id_i);

    // AES32 round on the latched head operands
    always_comb begin
        w_byte = r_x_rs2[7:0];
        case (r_x_bs)
            2'd1:    w_byte = r_x_rs2[15:8];
            2'd2:    w_byte = r_x_rs2[23:16];
            2'd3:    w_byte = r_x_rs2[31:24];
            default: w_byte = r_x_rs2[7:0];
        endcase
        w_sb  = r_x_dec ? f_isbox(w_byte) : f_sbox(w_byte);
        w_mix = {24'h000000, w_sb};
        if (r_x_mix) begin
            if (r_x_dec) w_mix = {f_gmul(w_sb, 8'h0b), f_gmul(w_sb, 8'h0d), f_gmul(w_sb, 8'h09), f_gmul(w_sb, 8'h0e)};
            else         w_mix = {f_xt(w_sb) ^ w_sb, w_sb, w_sb, f_xt(w_sb)};
        end
        case (r_x_bs)
            2'd1:    w_rot = {w_mix[23:0], w_mix[31:24]};
            2'd2:    w_rot = {w_mix[15:0], w_mix[31:16]};
            2'd3:    w_rot = {w_mix[7:0],  w_mix[31:8]};
            default: w_rot = w_mix;
        endcase
        w_result = r_x_rs1 ^ w_rot;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_latch     = 1'b0;
        w_res_load  = 1'b0;
        w_res_done  = 1'b0;
        case (r_state)
            S_IDLE: if (r_count != '0) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (r_kill[r_rd_ptr]) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cmt[r_rd_ptr]) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_cnt == '0) begin
                    w_res_load  = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (result_ready_i) begin
                    w_pop       = 1'b1;
                    w_res_done  = 1'b1;
                    w_state_nxt = ((r_count > CNT_W'(1)) || w_push) ? S_WAIT : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Queue bookkeeping, commit/kill flags, latency counter and result registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_vld       <= '0;
            r_cmt       <= '0;
            r_kill      <= '0;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_data  <= '0;
            r_res_rd    <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (r_vld[i] && commit_valid_i && (r_id[i] == commit_id_i)) begin
                    if (!commit_kill_i)  r_cmt[i]  <= 1'b1;
                    else if (!r_cmt[i])  r_kill[i] <= 1'b1;
                end
            end
            if (w_pop) begin
                r_vld[r_rd_ptr]  <= 1'b0;
                r_cmt[r_rd_ptr]  <= 1'b0;
                r_kill[r_rd_ptr] <= 1'b0;
                r_rd_ptr         <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push) begin
                r_vld[r_wr_ptr]  <= 1'b1;
                r_cmt[r_wr_ptr]  <= w_new_match && !commit_kill_i;
                r_kill[r_wr_ptr] <= w_new_match && commit_kill_i;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_latch)                              r_cnt <= LAT_W'(FU_LATENCY - 1);
            else if (r_state == S_EXEC && r_cnt != '0) r_cnt <= r_cnt - LAT_W'(1);
            if (w_res_load) begin
                r_res_valid <= 1'b1;
                r_res_id    <= r_x_id;
                r_res_data  <= w_result;
                r_res_rd    <= r_x_rd;
            end else if (w_res_done) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    // Entry payload and head operand latch carry no reset; validity is tracked above
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_id[r_wr_ptr]  <= issue_id_i;
            r_rs1[r_wr_ptr] <= issue_rs0_i;
            r_rs2[r_wr_ptr] <= issue_rs1_i;
            r_bs[r_wr_ptr]  <= issue_instr_i[31:30];
            r_dec[r_wr_ptr] <= issue_instr_i[27];
            r_mix[r_wr_ptr] <= issue_instr_i[26];
            r_rd[r_wr_ptr]  <= issue_instr_i[11:7];
        end
        if (w_latch) begin
            r_x_id  <= r_id[r_rd_ptr];
            r_x_rs1 <= r_rs1[r_rd_ptr];
            r_x_rs2 <= r_rs2[r_rd_ptr];
            r_x_bs  <= r_bs[r_rd_ptr];
            r_x_dec <= r_dec[r_rd_ptr];
            r_x_mix <= r_mix[r_rd_ptr];
            r_x_rd  <= r_rd[r_rd_ptr];
        end
    end

    assign result_valid_o = r_res_valid;
    assign result_we_o    = r_res_valid;
    assign result_id_o    = r_res_id;
    assign result_data_o  = r_res_data;
    assign result_rd_o    = r_res_rd;

endmodule

// File: tb/tb_cv32e40x_xif_aes_queue.sv
// Self-checking bench for cv32e40x_xif_aes_queue: directed offloads with a scoreboard of expected
// results built from an independent AES table model.
module tb_cv32e40x_xif_aes_queue;

    localparam logic [4:0] F5_ESI  = 5'b10001;
    localparam logic [4:0] F5_ESMI = 5'b10011;
    localparam logic [4:0] F5_DSI  = 5'b10101;
    localparam logic [4:0] F5_DSMI = 5'b10111;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [31:0] issue_instr_i;
    logic [3:0]  issue_id_i;
    logic [31:0] issue_rs0_i;
    logic [31:0] issue_rs1_i;
    logic [1:0]  issue_rs_valid_i;
    logic        issue_accept_o;
    logic        issue_writeback_o;
    logic        commit_valid_i;
    logic [3:0]  commit_id_i;
    logic        commit_kill_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [3:0]  result_id_o;
    logic [31:0] result_data_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;

    always #5 clk = ~clk;

    cv32e40x_xif_aes_queue dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .issue_valid_i     (issue_valid_i),
        .issue_ready_o     (issue_ready_o),
        .issue_instr_i     (issue_instr_i),
        .issue_id_i        (issue_id_i),
        .issue_rs0_i       (issue_rs0_i),
        .issue_rs1_i       (issue_rs1_i),
        .issue_rs_valid_i  (issue_rs_valid_i),
        .issue_accept_o    (issue_accept_o),
        .issue_writeback_o (issue_writeback_o),
        .commit_valid_i    (commit_valid_i),
        .commit_id_i       (commit_id_i),
        .commit_kill_i     (commit_kill_i),
        .result_valid_o    (result_valid_o),
        .result_ready_i    (result_ready_i),
        .result_id_o       (result_id_o),
        .result_data_o     (result_data_o),
        .result_rd_o       (result_rd_o),
        .result_we_o       (result_we_o)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [4:0]  rd;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] t_sbox  [256];
    logic [7:0] t_isbox [256];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Carry-less product reduced modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'h0000;
        for (int i = 0; i < 8; i++)
            if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
        return prod[7:0];
    endfunction

    function automatic logic [7:0] m_inv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        for (int y = 1; y < 256; y++)
            if (m_mul(a, 8'(y)) == 8'h01) return 8'(y);
        return 8'h00;
    endfunction

    function automatic logic [31:0] m_aes(input logic [4:0] f5, input logic [1:0] bs,
                                          input logic [31:0] rs1, input logic [31:0] rs2);
        logic [7:0]  x;
        logic [7:0]  s;
        logic [31:0] w;
        logic [63:0] d;
        int          sh;
        sh = 8 * int'(bs);
        x  = 8'(rs2 >> sh);
        s  = (f5 == F5_DSI || f5 == F5_DSMI) ? t_isbox[x] : t_sbox[x];
        case (f5)
            F5_ESMI: w = {m_mul(s, 8'h03), s, s, m_mul(s, 8'h02)};
            F5_DSMI: w = {m_mul(s, 8'h0b), m_mul(s, 8'h0d), m_mul(s, 8'h09), m_mul(s, 8'h0e)};
            default: w = {24'h000000, s};
        endcase
        d = {w, w} << sh;
        return rs1 ^ d[63:32];
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] f5, input logic [1:0] bs, input logic [4:0] rd);
        return {bs, f5, 5'd11, 5'd10, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic do_issue(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [3:0] id, input logic [1:0] rsv, input bit cmt,
                            input bit exp_acc, input bit retire);
        int n;
        exp_t e;
        issue_valid_i    = 1'b1;
        issue_instr_i    = instr;
        issue_id_i       = id;
        issue_rs0_i      = rs1;
        issue_rs1_i      = rs2;
        issue_rs_valid_i = rsv;
        commit_valid_i   = cmt;
        commit_id_i      = id;
        commit_kill_i    = 1'b0;
        n = 0;
        @(negedge clk);
        while (!issue_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!issue_ready_o) check_eq("issue_ready_timeout", 32'(issue_ready_o), 32'd1);
        check_eq("issue_accept", 32'(issue_accept_o), 32'(exp_acc));
        check_eq("issue_writeback", 32'(issue_writeback_o), 32'(exp_acc));
        if (retire) begin
            e.id   = id;
            e.data = m_aes(instr[29:25], instr[31:30], rs1, rs2);
            e.rd   = instr[11:7];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        issue_valid_i  = 1'b0;
        commit_valid_i = 1'b0;
    endtask

    task automatic do_commit(input logic [3:0] id, input bit kill);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
        @(posedge clk);
        #1;
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || result_valid_o) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("drain_sb_empty", 32'(sb.size()), 32'd0);
        check_eq("drain_valid_low", 32'(result_valid_o), 32'd0);
    endtask

    // Result port monitor: every retiring handshake must match the scoreboard head
    always @(negedge clk) begin
        if (!rst_i && result_valid_o && result_ready_i) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_result_id", 32'(result_id_o), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("res_id", 32'(result_id_o), 32'(e.id));
                check_eq("res_data", result_data_o, e.data);
                check_eq("res_rd", 32'(result_rd_o), 32'(e.rd));
                check_eq("res_we", 32'(result_we_o), 32'd1);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [4:0] ops [4];
        logic [7:0] b;
        logic [7:0] s;
        logic [3:0] hold_id;
        logic [31:0] hold_data;
        int n;
        ops[0] = F5_ESI; ops[1] = F5_ESMI; ops[2] = F5_DSI; ops[3] = F5_DSMI;

        for (int x = 0; x < 256; x++) begin
            b = m_inv(8'(x));
            for (int i = 0; i < 8; i++)
                s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8]
                     ^ ((8'h63 >> i) & 8'h01) != 8'h00;
            t_sbox[x]  = s;
            t_isbox[s] = 8'(x);
        end

        rst_i = 1'b1;
        issue_valid_i = 1'b0; issue_instr_i = '0; issue_id_i = '0;
        issue_rs0_i = '0; issue_rs1_i = '0; issue_rs_valid_i = '0;
        commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0;
        result_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", 32'(issue_ready_o), 32'd1);
        check_eq("rst_valid", 32'(result_valid_o), 32'd0);
        check_eq("rst_id", 32'(result_id_o), 32'd0);
        check_eq("rst_data", result_data_o, 32'd0);
        check_eq("rst_rd", 32'(result_rd_o), 32'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // aes32esi of zero: known S-box value, minimum latency
        do_issue(mk(F5_ESI, 2'd0, 5'd3), 32'h0, 32'h0, 4'd1, 2'b11, 1'b1, 1'b1, 1'b0);
        begin
            exp_t e;
            e.id = 4'd1; e.data = 32'h0000_0063; e.rd = 5'd3;
            sb.push_back(e);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("lat_not_early", 32'(result_valid_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("lat_on_time", 32'(result_valid_o), 32'd1);
        wait_drain();

        // aes32dsi: inverse S-box of 0x63 is 0
        do_issue(mk(F5_DSI, 2'd0, 5'd4), 32'hFFFF_FFFF, 32'h0000_0063, 4'd2, 2'b11, 1'b1, 1'b1, 1'b0);
        begin
            exp_t e;
            e.id = 4'd2; e.data = 32'hFFFF_FFFF; e.rd = 5'd4;
            sb.push_back(e);
        end
        wait_drain();

        // Fill to DEPTH without commits, then commit in order
        for (int k = 0; k < 4; k++)
            do_issue(mk(ops[k], 2'(k), 5'(k + 5)), $urandom, $urandom, 4'(k + 1), 2'b11, 1'b0, 1'b1, 1'b1);
        issue_valid_i = 1'b1;
        issue_instr_i = mk(F5_ESI, 2'd0, 5'd1);
        issue_id_i    = 4'd9;
        issue_rs_valid_i = 2'b11;
        @(negedge clk);
        check_eq("full_ready_low", 32'(issue_ready_o), 32'd0);
        check_eq("full_no_accept", 32'(issue_accept_o), 32'd0);
        @(posedge clk);
        #1;
        issue_valid_i = 1'b0;
        for (int k = 1; k <= 4; k++) do_commit(4'(k), 1'b0);
        wait_drain();
        check_eq("after_fill_ready", 32'(issue_ready_o), 32'd1);

        // Kill in the middle, commit-then-kill ignored, rejected requests
        do_issue(mk(F5_ESMI, 2'd1, 5'd10), $urandom, $urandom, 4'd5, 2'b11, 1'b0, 1'b1, 1'b1);
        do_issue(mk(F5_DSMI, 2'd2, 5'd11), $urandom, $urandom, 4'd6, 2'b11, 1'b0, 1'b1, 1'b0);
        do_issue(mk(F5_DSI,  2'd3, 5'd12), $urandom, $urandom, 4'd7, 2'b11, 1'b0, 1'b1, 1'b1);
        do_commit(4'd6, 1'b1);
        do_commit(4'd5, 1'b0);
        do_commit(4'd7, 1'b0);
        do_issue(mk(F5_ESI, 2'd2, 5'd13), $urandom, $urandom, 4'd8, 2'b11, 1'b1, 1'b1, 1'b1);
        do_commit(4'd8, 1'b1);
        do_issue({mk(F5_ESI, 2'd0, 5'd1)} ^ 32'h0000_0038, 32'h1, 32'h2, 4'd9, 2'b11, 1'b0, 1'b0, 1'b0);
        do_issue(mk(F5_ESI, 2'd0, 5'd1), 32'h1, 32'h2, 4'd10, 2'b01, 1'b0, 1'b0, 1'b0);
        do_issue(mk(5'b10000, 2'd0, 5'd1), 32'h1, 32'h2, 4'd11, 2'b11, 1'b0, 1'b0, 1'b0);
        wait_drain();
        check_eq("after_kill_ready", 32'(issue_ready_o), 32'd1);

        // Back-to-back random offloads, all ops and byte selects
        for (int k = 0; k < 20; k++)
            do_issue(mk(ops[k % 4], 2'($urandom_range(0, 3)), 5'($urandom_range(1, 31))),
                     $urandom, $urandom, 4'(k), 2'b11, 1'b1, 1'b1, 1'b1);
        wait_drain();

        // Backpressure: result held stable while ready is low
        result_ready_i = 1'b0;
        do_issue(mk(F5_ESMI, 2'd3, 5'd20), $urandom, $urandom, 4'd12, 2'b11, 1'b1, 1'b1, 1'b1);
        n = 0;
        @(negedge clk);
        while (!result_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp_valid_seen", 32'(result_valid_o), 32'd1);
        hold_id   = sb[0].id;
        hold_data = sb[0].data;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("bp_valid_hold", 32'(result_valid_o), 32'd1);
            check_eq("bp_id_hold", 32'(result_id_o), 32'(hold_id));
            check_eq("bp_data_hold", result_data_o, hold_data);
        end
        @(posedge clk);
        #1;
        result_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_pop_next", 32'(result_valid_o), 32'd0);

        // Reset while the head executes with three entries queued
        do_issue(mk(F5_ESI, 2'd0, 5'd1), $urandom, $urandom, 4'd1, 2'b11, 1'b1, 1'b1, 1'b0);
        do_issue(mk(F5_ESI, 2'd1, 5'd2), $urandom, $urandom, 4'd2, 2'b11, 1'b0, 1'b1, 1'b0);
        do_issue(mk(F5_ESI, 2'd2, 5'd3), $urandom, $urandom, 4'd3, 2'b11, 1'b0, 1'b1, 1'b0);
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("midrst_valid", 32'(result_valid_o), 32'd0);
        check_eq("midrst_ready", 32'(issue_ready_o), 32'd1);
        check_eq("midrst_data", result_data_o, 32'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        do_commit(4'd2, 1'b0);
        do_commit(4'd3, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("midrst_no_ghost", 32'(result_valid_o), 32'd0);
        check_eq("midrst_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
